// File: rtl/alu_seq.sv
// Registered ALU: single-cycle add/sub/logic ops and a WIDTH-cycle shift-add multiply,
// with a selectively loaded C/Z/N/V flags register.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             flags_we,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             overflow_flag
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d, acc_step;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fwe_q, fwe_d;
    logic             mul_last;

    logic [WIDTH-1:0] out_d;
    logic             valid_d, busy_d;
    logic             c_d, z_d, n_d, v_d;

    logic [WIDTH-1:0] addend, res;
    logic             cin, ovf;
    logic [WIDTH:0]   sum;

    // Single-cycle datapath; ADC/SBC take the carry straight from the flags register.
    always_comb begin
        addend = b;
        cin    = 1'b0;
        case (op)
            OP_SUB:  begin addend = ~b; cin = 1'b1;       end
            OP_ADC:  begin addend = b;  cin = carry_flag; end
            OP_SBC:  begin addend = ~b; cin = carry_flag; end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, addend} + (WIDTH+1)'(cin);
        ovf = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = sum[WIDTH-1:0];
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && op == OP_MUL) state_nxt = S_MUL;
            S_MUL:   if (mul_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_d    = out;
        valid_d  = 1'b0;
        c_d      = carry_flag;
        z_d      = zero_flag;
        n_d      = negative_flag;
        v_d      = overflow_flag;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        fwe_d    = fwe_q;
        busy_d   = (state_nxt == S_MUL);
        case (state)
            S_IDLE: begin
                if (start && op != OP_MUL) begin
                    out_d   = res;
                    valid_d = 1'b1;
                    if (flags_we) begin
                        c_d = ~op[2] & sum[WIDTH];
                        v_d = ~op[2] & ovf;
                        z_d = (res == '0);
                        n_d = res[WIDTH-1];
                    end
                end else if (start) begin
                    mcand_d  = PW'(a);
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    fwe_d    = flags_we;
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (mul_last) begin
                    out_d   = acc_step[WIDTH-1:0];
                    valid_d = 1'b1;
                    if (fwe_q) begin
                        c_d = |acc_step[PW-1:WIDTH];
                        v_d = 1'b0;
                        z_d = (acc_step[WIDTH-1:0] == '0);
                        n_d = acc_step[WIDTH-1];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out           <= '0;
            valid         <= 1'b0;
            busy          <= 1'b0;
            carry_flag    <= 1'b0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            overflow_flag <= 1'b0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            fwe_q         <= 1'b0;
        end else begin
            out           <= out_d;
            valid         <= valid_d;
            busy          <= busy_d;
            carry_flag    <= c_d;
            zero_flag     <= z_d;
            negative_flag <= n_d;
            overflow_flag <= v_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            fwe_q         <= fwe_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         start, flags_we;
    logic [W-1:0] out;
    logic         valid, busy;
    logic         carry_flag, zero_flag, negative_flag, overflow_flag;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] m_out;
    logic         m_c, m_z, m_n, m_v;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start), .flags_we(flags_we),
        .out(out), .valid(valid), .busy(busy), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .negative_flag(negative_flag), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] dut_flags();
        return {carry_flag, zero_flag, negative_flag, overflow_flag};
    endfunction

    // Reference: plain signed/unsigned integer arithmetic on the operand values.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic fwe);
        int unsigned ux, uy, ci, bor, p;
        int          sx, sy, s, t;
        logic        c, v;
        logic signed [W-1:0] xs, ys;
        ux = x; uy = y; ci = m_c; bor = 1 - ci;
        xs = x; ys = y; sx = xs; sy = ys;
        c = 1'b0; v = 1'b0; s = 0;
        case (o)
            3'd0: begin t = ux + uy;       c = (t >= 256); s = sx + sy;       end
            3'd1: begin t = ux - uy;       c = (ux >= uy); s = sx - sy;       end
            3'd2: begin t = ux + uy + ci;  c = (t >= 256); s = sx + sy + ci;  end
            3'd3: begin t = ux - uy - bor; c = (ux >= uy + bor); s = sx - sy - bor; end
            3'd4: t = ux & uy;
            3'd5: t = ux | uy;
            3'd6: t = ux ^ uy;
            default: begin p = ux * uy; t = p; c = (p >= 256); end
        endcase
        if (o <= 3'd3) v = (s > 127) || (s < -128);
        m_out = W'(t);
        if (fwe) begin
            m_c = c;
            m_v = v;
            m_z = (m_out == '0);
            m_n = m_out[W-1];
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_out"}, 32'(out), 32'(m_out));
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_flags"}, 32'(dut_flags()), 32'({m_c, m_z, m_n, m_v}));
    endtask

    // Issue one op (called away from the clock edge); returns 1 time unit after its completion edge.
    task automatic apply(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic fwe, input bit noisy);
        a = x; b = y; op = o; flags_we = fwe; start = 1'b1;
        @(posedge clk); #1;
        model(o, x, y, fwe);
        if (o != 3'd7) begin
            check_result("alu");
        end else begin
            check("mul_busy0", 32'(busy), 32'd1);
            check("mul_valid0", 32'(valid), 32'd0);
            for (int i = 1; i <= W; i++) begin
                if (noisy) begin
                    a = W'($urandom); b = W'($urandom); op = 3'($urandom);
                    flags_we = 1'($urandom); start = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                if (i < W) begin
                    check("mul_busy", 32'(busy), 32'd1);
                    check("mul_novalid", 32'(valid), 32'd0);
                end
            end
            check("mul_done_busy", 32'(busy), 32'd0);
            check_result("mul");
        end
        start = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        start = 1'b0;
        @(posedge clk); #1;
        check(tag, 32'(valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0; flags_we = 1'b0;
        m_out = '0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'(dut_flags()), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        apply(3'd0, 8'h7F, 8'h01, 1'b1, 1'b0);
        check("add_ovf_out", 32'(out), 32'h80);
        check("add_ovf_flags", 32'(dut_flags()), 32'b0011);
        apply(3'd1, 8'h05, 8'h05, 1'b1, 1'b0);
        check("sub_eq_flags", 32'(dut_flags()), 32'b1100);
        apply(3'd1, 8'h03, 8'h05, 1'b1, 1'b0);
        check("sub_neg_out", 32'(out), 32'hFE);
        check("sub_neg_flags", 32'(dut_flags()), 32'b0010);
        idle_check("valid_drop");

        apply(3'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
        check("chain_add_c", 32'(carry_flag), 32'd1);
        apply(3'd2, 8'h00, 8'h00, 1'b1, 1'b0);
        check("chain_adc_out", 32'(out), 32'h01);
        check("chain_adc_c", 32'(carry_flag), 32'd0);
        apply(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
        check("nowe_add_flags", 32'(dut_flags()), 32'b0000);
        apply(3'd2, 8'h00, 8'h00, 1'b0, 1'b0);
        check("nowe_adc_out", 32'(out), 32'h00);

        apply(3'd7, 8'h0D, 8'h0B, 1'b1, 1'b1);
        check("mul_8f_out", 32'(out), 32'h8F);
        check("mul_8f_cn", 32'({carry_flag, negative_flag}), 32'b01);
        idle_check("mul_single_valid");
        apply(3'd7, 8'h10, 8'h10, 1'b1, 1'b1);
        check("mul_ovf_cz", 32'({carry_flag, zero_flag}), 32'b11);

        for (int i = 0; i < 300; i++) begin
            apply(3'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_check("rand_idle");
        end

        // Reset in the middle of a multiply.
        a = 8'h55; b = 8'hAA; op = 3'd7; flags_we = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_flags", 32'(dut_flags()), 32'd0);
        m_out = '0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        @(negedge clk); rst = 1'b0;
        apply(3'd7, 8'h03, 8'h04, 1'b1, 1'b0);
        check("postrst_mul_out", 32'(out), 32'h0C);
        idle_check("postrst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

- Parametrised, registered successor to the CPU's combinational add/subtract ALU.
- Operations: add, subtract, add/subtract with carry, AND, OR, XOR, and an iterative shift-add multiply.
- Keeps a flags register (C, Z, N, V) that the control unit loads selectively; the carry flag feeds ADC/SBC chaining.
- Sits between the A/B registers and the bus driver; the controller issues `start` and watches `busy`/`valid`.

## Interface

- `WIDTH`, default 8: data width of operands and result (≥ 2).
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `op` input 3: operation code, sampled with `start`.
- `start` input 1: issue the operation; honoured only when `busy`=0.
- `flags_we` input 1: sampled with `start`; 1 means the flags register is updated when this operation completes.
- `out` output WIDTH: registered result of the last completed operation.
- `valid` output 1: one-cycle pulse when `out` is updated.
- `busy` output 1: high while a multiply is iterating.
- `carry_flag`, `zero_flag`, `negative_flag`, `overflow_flag` output 1 each: flags register.

## Operation

- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 ADC: a+b+C.
  - 011 SBC: a+~b+C.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 MUL: low WIDTH bits of a*b, unsigned.
- Arithmetic uses a WIDTH+1-bit sum. The result is the sum modulo 2^WIDTH; the carry is bit WIDTH of the sum.
- SUB/SBC carry is no-borrow: C=1 iff a ≥ b for SUB, and iff a ≥ b+(1−C_old) for SBC.
- C for ADC/SBC is the flags-register value at the cycle `start` is sampled.
- Flags on completion, applied only if the latched `flags_we`=1:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - ADD/ADC/SUB/SBC: C = carry out; V = signed overflow (operand-sign rule applied to a and the effective addend).
  - AND/OR/XOR: C=0, V=0.
  - MUL: C = 1 iff the upper WIDTH bits of the full 2·WIDTH product are nonzero; V=0.
- `out` and `valid` update on every completion, regardless of `flags_we`.
- FSM states:
  - IDLE: on `start`, latch a, b, op, `flags_we` and the carry.
    - op≠111: compute, load `out` and flags, pulse `valid`, stay in IDLE.
    - op=111: clear the accumulator and counter, go to MUL.
  - MUL: one shift-add iteration per cycle, LSB-first on the latched b, with a 2·WIDTH-bit accumulator. After WIDTH iterations, load `out` and flags, pulse `valid`, return to IDLE.
- `start` while `busy`=1 is ignored entirely; the operation is not queued.
- Operand, `op` and `flags_we` changes after the start cycle have no effect on the in-flight operation.

## Timing

- Reset (asynchronous, immediate): state IDLE; `out`=0, `valid`=0, `busy`=0, all four flags 0; accumulator and counter cleared.
- Non-MUL ops: `start` sampled at edge k. `out`, flags and `valid`=1 appear after edge k; `valid` drops after edge k+1 unless a new op completes.
- Back-to-back non-MUL ops are accepted on consecutive cycles, giving one result per cycle. ADC issued the cycle after ADD sees the flag written by that ADD.
- MUL: `start` sampled at edge k.
  - `busy`=1 after edges k … k+WIDTH−1.
  - At edge k+WIDTH: `out`, flags and `valid`=1 appear, and `busy`=0.
  - Latency is WIDTH cycles. A new `start` is accepted at edge k+WIDTH+1 at the earliest. `start` high at edge k+WIDTH (`busy` still 1 at that edge) is ignored.
- Reset asserted mid-MUL aborts it: no `valid`, and the flags go to 0. The first `start` sampled after reset release is honoured.
- `valid` is never high for two consecutive cycles from a single operation.

## Test plan

- ADD, WIDTH=8, a=0x7F, b=0x01, `flags_we`=1: one cycle later `out`=0x80, `valid` pulse, N=1, V=1, C=0, Z=0.
- SUB 0x05−0x05: `out`=0x00, Z=1, C=1. Next cycle SUB 0x03−0x05: `out`=0xFE, C=0, N=1, V=0.
- Carry chain: ADD 0xFF+0x01 then ADC 0x00+0x00 on consecutive cycles: `out`=0x00 with C=1, then `out`=0x01 with C=0. Repeat with `flags_we`=0 on the ADD: ADC gives 0x00 and the flags remain at their prior values.
- MUL 0x0D×0x0B: `busy` high exactly 8 cycles, then `out`=0x8F, C=0, N=1. MUL 0x10×0x10: `out`=0x00, C=1, Z=1.
- `start`/ADD asserted during a MUL's busy cycles: no extra `valid`, and the MUL result is unchanged.
- `rst` pulsed at iteration 4 of a MUL: all outputs 0 immediately and no `valid`. A MUL 0x03×0x04 issued the next cycle yields `out`=0x0C after 8 cycles.
